// File: rtl/mossbauer_window_gate_if.sv
// Bus bundle for mossbauer_window_gate: velocity samples, window thresholds, detector input,
// and the per-channel gate/hit/count results. master = stimulus side, slave = gate block.
interface mossbauer_window_gate_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned VW  = 12,
    parameter int unsigned EW  = 24
);
    logic [VW-1:0]     vel;
    logic              vel_valid;
    logic [NCH*VW-1:0] thr_lo;
    logic [NCH*VW-1:0] thr_hi;
    logic [NCH-1:0]    ch_en;
    logic              rf2;
    logic              clr;
    logic [NCH-1:0]    gate;
    logic [NCH-1:0]    hit;
    logic [NCH*EW-1:0] evt_cnt;
    logic [NCH-1:0]    sat;

    modport master (
        output vel, vel_valid, thr_lo, thr_hi, ch_en, rf2, clr,
        input  gate, hit, evt_cnt, sat
    );

    modport slave (
        input  vel, vel_valid, thr_lo, thr_hi, ch_en, rf2, clr,
        output gate, hit, evt_cnt, sat
    );
endinterface

// File: rtl/mossbauer_window_gate.sv
// N-channel velocity-window coincidence gate: per-channel [lo,hi) window FSM with hysteresis,
// timeout lockout and saturating RF2 event counters. Optional MOSS_DEADTIME_EN adds per-channel dead time.
module mossbauer_window_gate #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned VW      = 12,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 20000,
    parameter int unsigned HYST    = 2,
    parameter int unsigned EW      = 24,
    parameter int unsigned DEAD    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mossbauer_window_gate_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_LOCK
    } state_e;

    localparam logic [VW:0]   HYST_X   = (VW+1)'(HYST);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    if (TIMEOUT == 0 || CW < $clog2(TIMEOUT + 1) || DEAD > 65535) begin : g_bad_cfg
        $error("mossbauer_window_gate: TIMEOUT must fit 1..2^CW-1 and DEAD must be <= 65535");
    end

    state_e          state_q [NCH];
    state_e          state_d [NCH];
    logic [CW-1:0]   tmo_q   [NCH];
    logic [CW-1:0]   tmo_d   [NCH];
    logic [EW-1:0]   evt_q   [NCH];
    logic [EW-1:0]   evt_d   [NCH];
    logic [NCH-1:0]  sat_q, sat_d;
    logic [NCH-1:0]  hit_q, hit_d;
    logic [NCH-1:0]  gate_w;
    logic [NCH-1:0]  enter_w, exit_w;
    logic [2:0]      rf2_sync_q, rf2_sync_d;
    logic            rf2_p;

`ifdef MOSS_DEADTIME_EN
    localparam int unsigned DW = (DEAD < 2) ? 1 : $clog2(DEAD + 1);
    logic [DW-1:0]   dead_q [NCH];
    logic [DW-1:0]   dead_d [NCH];
`endif

    // Two flops synchronise rf2; the third only serves the rising-edge detect.
    assign rf2_sync_d = {rf2_sync_q[1:0], bus.rf2};
    assign rf2_p      = rf2_sync_q[1] & ~rf2_sync_q[2];

    // Window compares run one bit wider so hi+HYST and lo-HYST never wrap.
    always_comb begin
        logic [VW:0] v_x, lo_x, hi_x;
        v_x     = {1'b0, bus.vel};
        lo_x    = '0;
        hi_x    = '0;
        enter_w = '0;
        exit_w  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            lo_x       = {1'b0, bus.thr_lo[i*VW +: VW]};
            hi_x       = {1'b0, bus.thr_hi[i*VW +: VW]};
            enter_w[i] = (v_x >= lo_x) && (v_x < hi_x);
            exit_w[i]  = ((lo_x >= HYST_X) && (v_x < lo_x - HYST_X)) || (v_x >= hi_x + HYST_X);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            tmo_d[i]   = tmo_q[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    if (bus.vel_valid && enter_w[i]) begin
                        state_d[i] = ST_OPEN;
                        tmo_d[i]   = '0;
                    end
                end
                ST_OPEN: begin
                    if (bus.vel_valid && exit_w[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (tmo_q[i] == TMO_LAST) begin
                        state_d[i] = ST_LOCK;
                    end else begin
                        tmo_d[i] = tmo_q[i] + 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (bus.vel_valid && exit_w[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (!bus.ch_en[i]) begin
                state_d[i] = ST_IDLE;
                tmo_d[i]   = '0;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            gate_w[i] = (state_q[i] == ST_OPEN);
        end
    end

    always_comb begin
        hit_d = '0;
        sat_d = sat_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            evt_d[i] = evt_q[i];
`ifdef MOSS_DEADTIME_EN
            dead_d[i] = dead_q[i];
            hit_d[i]  = rf2_p && gate_w[i] && (dead_q[i] == '0);
            if (state_q[i] == ST_IDLE || state_d[i] == ST_IDLE) begin
                dead_d[i] = '0;
            end else if (hit_d[i]) begin
                dead_d[i] = DW'(DEAD);
            end else if (dead_q[i] != '0) begin
                dead_d[i] = dead_q[i] - 1'b1;
            end
`else
            hit_d[i] = rf2_p && gate_w[i];
`endif
            // clr overrides a coincident count but the hit pulse itself still goes out.
            if (bus.clr) begin
                evt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else begin
                if (hit_d[i] && (evt_q[i] != '1)) begin
                    evt_d[i] = evt_q[i] + 1'b1;
                end
                sat_d[i] = sat_q[i] | (&evt_d[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf2_sync_q <= '0;
            hit_q      <= '0;
            sat_q      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                tmo_q[i]   <= '0;
                evt_q[i]   <= '0;
`ifdef MOSS_DEADTIME_EN
                dead_q[i]  <= '0;
`endif
            end
        end else begin
            rf2_sync_q <= rf2_sync_d;
            hit_q      <= hit_d;
            sat_q      <= sat_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                tmo_q[i]   <= tmo_d[i];
                evt_q[i]   <= evt_d[i];
`ifdef MOSS_DEADTIME_EN
                dead_q[i]  <= dead_d[i];
`endif
            end
        end
    end

    always_comb begin
        bus.gate    = gate_w;
        bus.hit     = hit_q;
        bus.sat     = sat_q;
        bus.evt_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            bus.evt_cnt[i*EW +: EW] = evt_q[i];
        end
    end

endmodule

// File: tb/tb_mossbauer_window_gate.sv
// Directed bench for mossbauer_window_gate (NCH=2, VW=12, TIMEOUT=16, HYST=2, EW=4, DEAD=8).
module tb_mossbauer_window_gate;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    mossbauer_window_gate_if #(.NCH(2), .VW(12), .EW(4)) bus ();

    mossbauer_window_gate #(
        .NCH(2), .VW(12), .CW(16), .TIMEOUT(16), .HYST(2), .EW(4), .DEAD(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        bus.vel       = v;
        bus.vel_valid = 1'b1;
        tick();
        bus.vel_valid = 1'b0;
    endtask

    task automatic open_gate0();
        send(12'd50);
        send(12'd150);
    endtask

    // 3-clk-wide rf2 pulse, 10-clk period; hit is expected on the 3rd edge after the rise.
    task automatic pulse(input logic exp_hit, input logic do_clr);
        bus.rf2 = 1'b1;
        tick();
        check("hit_early1", 32'(bus.hit), 32'd0);
        tick();
        check("hit_early2", 32'(bus.hit), 32'd0);
        bus.clr = do_clr;
        tick();
        bus.clr = 1'b0;
        bus.rf2 = 1'b0;
        check("hit_rise", 32'(bus.hit), {31'd0, exp_hit});
        tick();
        check("hit_once", 32'(bus.hit), 32'd0);
        repeat (6) tick();
    endtask

    initial begin
        int n;
        int nh;
        n_chk         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.vel       = '0;
        bus.vel_valid = 1'b0;
        bus.thr_lo    = {12'd300, 12'd100};
        bus.thr_hi    = {12'd300, 12'd200};
        bus.ch_en     = 2'b11;
        bus.rf2       = 1'b0;
        bus.clr       = 1'b0;
        repeat (3) tick();
        check("rst_gate", 32'(bus.gate), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_evt", 32'(bus.evt_cnt), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);
        rst_n = 1'b1;
        tick();

        // window edges and hysteresis
        send(12'd99);  check("w_99", 32'(bus.gate), 32'd0);
        send(12'd100); check("w_100", 32'(bus.gate), 32'd1);
        send(12'd99);  check("w_hyst99", 32'(bus.gate), 32'd1);
        send(12'd98);  check("w_hyst98", 32'(bus.gate), 32'd1);
        send(12'd97);  check("w_exit97", 32'(bus.gate), 32'd0);
        send(12'd150); check("w_150", 32'(bus.gate), 32'd1);
        send(12'd201); check("w_hyst201", 32'(bus.gate), 32'd1);
        send(12'd202); check("w_exit202", 32'(bus.gate), 32'd0);
        send(12'd300); check("w_ch1_empty", 32'(bus.gate), 32'd0);

        // timeout and lockout
        bus.vel       = 12'd150;
        bus.vel_valid = 1'b1;
        n = 0;
        repeat (40) begin
            tick();
            if (bus.gate[0]) n++;
        end
        bus.vel_valid = 1'b0;
        check("tmo_len", 32'(n), 32'd16);
        check("tmo_lock", 32'(bus.gate), 32'd0);
        send(12'd50);  check("lock_exit", 32'(bus.gate), 32'd0);
        send(12'd150); check("lock_rearm", 32'(bus.gate), 32'd1);
        bus.ch_en = 2'b10;
        tick();
        check("ch_en_off", 32'(bus.gate), 32'd0);
        bus.ch_en = 2'b11;

        // counted hits in an open gate
        for (int k = 0; k < 5; k++) begin
            open_gate0();
            pulse(1'b1, 1'b0);
        end
        check("evt_5", 32'(bus.evt_cnt), 32'd5);
        send(12'd50);
        check("gate_closed", 32'(bus.gate), 32'd0);
        pulse(1'b0, 1'b0);
        check("evt_no_gate", 32'(bus.evt_cnt), 32'd5);

        // saturation and clr
        for (int k = 0; k < 15; k++) begin
            open_gate0();
            pulse(1'b1, 1'b0);
        end
        check("evt_sat", 32'(bus.evt_cnt), 32'd15);
        check("sat_set", 32'(bus.sat), 32'd1);
        open_gate0();
        pulse(1'b1, 1'b1);
        check("clr_evt", 32'(bus.evt_cnt), 32'd0);
        check("clr_sat", 32'(bus.sat), 32'd0);
        open_gate0();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_keeps_gate", 32'(bus.gate), 32'd1);

        // asynchronous reset mid-OPEN
        for (int k = 0; k < 7; k++) begin
            open_gate0();
            pulse(1'b1, 1'b0);
        end
        check("evt_7", 32'(bus.evt_cnt), 32'd7);
        open_gate0();
        check("pre_rst_gate", 32'(bus.gate), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gate", 32'(bus.gate), 32'd0);
        check("arst_evt", 32'(bus.evt_cnt), 32'd0);
        check("arst_hit", 32'(bus.hit), 32'd0);
        check("arst_sat", 32'(bus.sat), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.gate), 32'd0);

        // closely spaced rf2 rises inside one gate window
        nh = 0;
        for (int c = 0; c < 24; c++) begin
            bus.rf2       = (c < 20) && ((c % 5) < 2);
            bus.vel       = 12'd150;
            bus.vel_valid = (c == 1);
            tick();
            if (bus.hit[0]) nh++;
        end
        bus.vel_valid = 1'b0;
`ifdef MOSS_DEADTIME_EN
        check("dead_hits", 32'(nh), 32'd2);
        check("dead_evt", 32'(bus.evt_cnt), 32'd2);
`else
        check("burst_hits", 32'(nh), 32'd4);
        check("burst_evt", 32'(bus.evt_cnt), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
